// File: rtl/knight_rider_pkg.sv
// Shared constants, direction enum and scan-step helpers for the Knight Rider LED scanner.
package knight_rider_pkg;

    localparam int NUM_LEDS = 8;
    localparam int PWM_BITS = 4;
    localparam int DUTY_W   = PWM_BITS + 1;

    // Duty thresholds: an LED is lit while pwm_cnt is below the threshold (out of 16).
    localparam int DUTY_FULL = 16;
    localparam int DUTY_DIM  = 4;
    localparam int TAIL_FULL = 4;
    localparam int TAIL_DIM  = 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    typedef logic [$clog2(NUM_LEDS)-1:0] pos_t;

    typedef struct packed {
        pos_t pos;
        dir_t dir;
    } scan_t;

    // Endpoints bounce without repeating, giving a 14-step period.
    function automatic scan_t scan_step(input scan_t s);
        scan_t n;
        n = s;
        if (s.dir == DIR_UP) begin
            if (s.pos == pos_t'(NUM_LEDS - 1)) begin
                n.dir = DIR_DOWN;
                n.pos = s.pos - 1'b1;
            end else begin
                n.pos = s.pos + 1'b1;
            end
        end else begin
            if (s.pos == '0) begin
                n.dir = DIR_UP;
                n.pos = s.pos + 1'b1;
            end else begin
                n.pos = s.pos - 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [NUM_LEDS-1:0] led_mask(input pos_t p);
        logic [NUM_LEDS-1:0] m;
        m = '0;
        m[p] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/knight_rider_pwm.sv
// Free-running 4-bit PWM counter with head/tail duty compares.
// Tail enable port exists only when KNIGHT_RIDER_TRAIL_EN is defined.
module knight_rider_pwm
    import knight_rider_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bright,
    output logic head_on
`ifdef KNIGHT_RIDER_TRAIL_EN
    ,
    output logic tail_on
`endif
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DUTY_W-1:0]   cnt_ext;
    logic [DUTY_W-1:0]   head_duty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign cnt_ext   = {1'b0, pwm_cnt};
    assign head_duty = bright ? DUTY_W'(DUTY_FULL) : DUTY_W'(DUTY_DIM);
    assign head_on   = (cnt_ext < head_duty);

`ifdef KNIGHT_RIDER_TRAIL_EN
    logic [DUTY_W-1:0] tail_duty;

    assign tail_duty = bright ? DUTY_W'(TAIL_FULL) : DUTY_W'(TAIL_DIM);
    assign tail_on   = (cnt_ext < tail_duty);
`endif

endmodule

// File: rtl/knight_rider_kolos_koblasz.sv
// Eight-LED bouncing scanner with selectable sweep rate and PWM brightness.
// Define KNIGHT_RIDER_TRAIL_EN to add a dim trailing LED at the previous position.
module knight_rider_kolos_koblasz
    import knight_rider_pkg::*;
#(
    parameter int FAST_DIV = 1024,
    parameter int SLOW_DIV = 4096
) (
    input  logic [7:0]          io_in,
    output logic [NUM_LEDS-1:0] io_out
);

    localparam int CNT_W = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;
    localparam logic [CNT_W-1:0] FAST_MAX = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] SLOW_MAX = CNT_W'(SLOW_DIV - 1);

    logic clk;
    logic rst;
    logic unused_io;

    assign clk       = io_in[0];
    assign rst       = io_in[1];
    assign unused_io = ^io_in[7:4];

    // Stage p0/p1: two-flop synchronizers for the asynchronous control pins.
    logic rate_sync_p0, rate_sync_p1;
    logic bright_sync_p0, bright_sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_sync_p0   <= 1'b0;
            rate_sync_p1   <= 1'b0;
            bright_sync_p0 <= 1'b0;
            bright_sync_p1 <= 1'b0;
        end else begin
            rate_sync_p0   <= io_in[2];
            rate_sync_p1   <= rate_sync_p0;
            bright_sync_p0 <= io_in[3];
            bright_sync_p1 <= bright_sync_p0;
        end
    end

    // The >= compare lets a slow-to-fast switch past the fast limit step at once.
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] step_max;
    logic             step_tick;

    assign step_max  = rate_sync_p1 ? FAST_MAX : SLOW_MAX;
    assign step_tick = (step_cnt >= step_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (step_tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    scan_t scan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '{pos: '0, dir: DIR_UP};
        end else if (step_tick) begin
            scan_q <= scan_step(scan_q);
        end
    end

    logic head_on;
    logic [NUM_LEDS-1:0] head_mask;
    logic [NUM_LEDS-1:0] led_pattern;

    assign head_mask = head_on ? led_mask(scan_q.pos) : '0;

`ifdef KNIGHT_RIDER_TRAIL_EN
    logic tail_on;
    logic had_step;
    pos_t tail_pos;
    logic [NUM_LEDS-1:0] tail_mask;

    knight_rider_pwm u_pwm (
        .clk     (clk),
        .rst     (rst),
        .bright  (bright_sync_p1),
        .head_on (head_on),
        .tail_on (tail_on)
    );

    // No previous position exists until the scan has moved once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            had_step <= 1'b0;
        end else if (step_tick) begin
            had_step <= 1'b1;
        end
    end

    assign tail_pos    = (scan_q.dir == DIR_UP) ? (scan_q.pos - 1'b1) : (scan_q.pos + 1'b1);
    assign tail_mask   = (tail_on && had_step) ? led_mask(tail_pos) : '0;
    assign led_pattern = head_mask | tail_mask;
`else
    knight_rider_pwm u_pwm (
        .clk     (clk),
        .rst     (rst),
        .bright  (bright_sync_p1),
        .head_on (head_on)
    );

    assign led_pattern = head_mask;
`endif

    // Stage p2: registered LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_out <= '0;
        end else begin
            io_out <= led_pattern;
        end
    end

endmodule

// File: tb/tb_knight_rider_kolos_koblasz.sv
// Directed bench for the Knight Rider scanner with FAST_DIV=4, SLOW_DIV=16.
// Define KNIGHT_RIDER_TRAIL_EN to exercise the trailing-LED build instead of the sweep checks.
module tb_knight_rider_kolos_koblasz;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rate = 1'b0;
    logic       bright = 1'b0;
    logic [3:0] junk = 4'h0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int tests = 0;
    int fails = 0;

    assign io_in = {junk, bright, rate, rst, clk};

    knight_rider_kolos_koblasz #(
        .FAST_DIV (4),
        .SLOW_DIV (16)
    ) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_change(output int n);
        logic [7:0] prev;
        prev = io_out;
        n = 0;
        do begin
            tick();
            n++;
        end while (io_out === prev && n < 200);
        check("change_timeout", int'(io_out !== prev), 1);
    endtask

    function automatic bit is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    initial begin
        logic [7:0] sweep [16];
        int n;
        int on_cnt;
        int bad_cnt;
        int hi6;

        sweep = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // Reset is asynchronous: output clears before any clock edge.
        #2 rst = 1'b1;
        #1 check("reset_async", int'(io_out), 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", int'(io_out), 8'h00);
        end

        rst = 1'b0; bright = 1'b1; rate = 1'b1; junk = 4'hF;
        repeat (3) tick();
        check("release_head", int'(io_out), 8'h01);

`ifndef KNIGHT_RIDER_TRAIL_EN
        for (int i = 1; i < 16; i++) begin
            repeat (4) tick();
            check($sformatf("fast_sweep_%0d", i), int'(io_out), int'(sweep[i]));
        end

        rate = 1'b0;
        wait_change(n);
        check("slow_enter_a", int'(io_out), 8'h04);
        wait_change(n);
        check("slow_enter_b", int'(io_out), 8'h08);
        wait_change(n);
        check("slow_period_1", n, 16);
        check("slow_led_1", int'(io_out), 8'h10);
        wait_change(n);
        check("slow_period_2", n, 16);
        check("slow_led_2", int'(io_out), 8'h20);

        // Counter reaches 10 just as the fast setting becomes visible.
        repeat (7) tick();
        rate = 1'b1;
        wait_change(n);
        check("switch_first", n, 4);
        check("switch_led_a", int'(io_out), 8'h40);
        wait_change(n);
        check("switch_period_a", n, 4);
        check("switch_led_b", int'(io_out), 8'h80);
        wait_change(n);
        check("switch_period_b", n, 4);
        check("switch_bounce", int'(io_out), 8'h40);

        bright = 1'b0;
        repeat (2) tick();
        on_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (io_out != 8'h00) on_cnt++;
            if (io_out != 8'h00 && !is_onehot(io_out)) bad_cnt++;
        end
        check("dim_on_cycles", on_cnt, 4);
        check("dim_other_bits", bad_cnt, 0);

        bright = 1'b1;
        repeat (2) tick();
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (is_onehot(io_out)) on_cnt++;
        end
        check("full_on_cycles", on_cnt, 16);

        n = 0;
        while (io_out !== 8'h20 && n < 64) begin
            tick();
            n++;
        end
        check("mid_find_pos5", int'(io_out), 8'h20);
        rst = 1'b1;
        #1 check("mid_reset_async", int'(io_out), 8'h00);
        tick();
        check("mid_reset_hold", int'(io_out), 8'h00);
        rst = 1'b0;
        repeat (3) tick();
        check("restart_head", int'(io_out), 8'h01);
        repeat (4) tick();
        check("restart_up_1", int'(io_out), 8'h02);
        repeat (4) tick();
        check("restart_up_2", int'(io_out), 8'h04);
`else
        rst = 1'b1;
        tick();
        rate = 1'b0;
        rst = 1'b0;
        bad_cnt = 0; on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if ((io_out & 8'hFE) != 8'h00) bad_cnt++;
            if (io_out[0]) on_cnt++;
        end
        check("trail_none_after_reset", bad_cnt, 0);
        check("trail_head_pos0", on_cnt, 16);

        // Step 8 (pos 6, moving down) lands on edge 128; its pattern shows for 16 cycles.
        repeat (112) tick();
        on_cnt = 0; hi6 = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (io_out[7]) on_cnt++;
            if (io_out[6]) hi6++;
        end
        check("trail_bit7_duty", on_cnt, 4);
        check("trail_head_pos6", hi6, 16);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
